// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types for the unified-memory arbiter:
//   t_arb_state - arbiter FSM states (IDLE, REQ, RSP)
//   t_arb_owner - which requester owns the in-flight transaction
//   t_mem_req   - captured request fields, also driven on the mem_* port
//   fetch_req() - builds the fixed-shape request used for instruction fetch
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } t_arb_state;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } t_arb_owner;

    typedef struct packed {
        logic [31:0] adrs;
        logic        wr_en;
        logic [3:0]  byt_en;
        logic        sign_ext;
        logic [31:0] wr_data;
    } t_mem_req;

    localparam t_mem_req MEM_REQ_ZERO = '{
        adrs:     32'h0000_0000,
        wr_en:    1'b0,
        byt_en:   4'b0000,
        sign_ext: 1'b0,
        wr_data:  32'h0000_0000
    };

    // Fetches are always full-word reads with no sign extension.
    function automatic t_mem_req fetch_req(input logic [31:0] adrs);
        t_mem_req r;
        r.adrs     = adrs;
        r.wr_en    = 1'b0;
        r.byt_en   = 4'b1111;
        r.sign_ext = 1'b0;
        r.wr_data  = 32'h0000_0000;
        return r;
    endfunction

endpackage

// File: rtl/arb_prio.sv
// ---------------------------------------------------------------------------
// arb_prio
// Combinational winner selection between fetch and data requesters.
// Data has priority unless the data-win streak has hit its limit.
// Ports:
//   i_if_req    - fetch request
//   i_dm_req    - data request
//   i_dwin_max  - data-win counter has reached its limit
//   o_gnt_if    - fetch wins (one-hot with o_gnt_dm, or both zero)
//   o_gnt_dm    - data wins
// ---------------------------------------------------------------------------
module arb_prio
    import cpu_pkg::*;
(
    input  logic i_if_req,
    input  logic i_dm_req,
    input  logic i_dwin_max,
    output logic o_gnt_if,
    output logic o_gnt_dm
);

    // Fetch wins when alone, or when data has used up its consecutive wins.
    always_comb begin
        o_gnt_if = i_if_req & (~i_dm_req | i_dwin_max);
        o_gnt_dm = i_dm_req & ~o_gnt_if;
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one variable-latency memory port between instruction fetch (if_*)
// and data access (dm_*). One transaction in flight at a time; data has
// fixed priority, bounded by MAX_DWIN consecutive wins while fetch waits.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   if_req/if_adrs            - fetch request in; if_gnt/if_rvalid/if_rdata out
//   dm_req/dm_* fields        - data request in; dm_gnt/dm_rvalid/dm_rdata out
//   mem_req/mem_* fields      - registered request to memory
//   mem_ready                 - memory accepts request
//   mem_rvalid/mem_rdata      - memory response (also write ack)
//   busy                      - transaction in flight
//   err                       - sticky: response seen outside RSP
// ---------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int MAX_DWIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adrs,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_wr_en,
    input  logic [3:0]  dm_byt_en,
    input  logic        dm_sign_ext,
    input  logic [31:0] dm_adrs,
    input  logic [31:0] dm_wr_data,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_wr_en,
    output logic [3:0]  mem_byt_en,
    output logic        mem_sign_ext,
    output logic [31:0] mem_adrs,
    output logic [31:0] mem_wr_data,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int              CNT_W    = $clog2(MAX_DWIN + 1);
    localparam logic [CNT_W-1:0] DWIN_LIM = CNT_W'(MAX_DWIN);

    t_arb_state       r_state;
    t_arb_owner       r_owner;
    logic [CNT_W-1:0] r_dwin_cnt;
    logic             r_err;
    logic             r_mem_req;
    t_mem_req         r_req;

    logic w_idle;
    logic w_in_rsp;
    logic w_gnt_if;
    logic w_gnt_dm;
    logic w_if_gnt;
    logic w_dm_gnt;

    assign w_idle   = (r_state == IDLE);
    assign w_in_rsp = (r_state == RSP);

    arb_prio u_prio (
        .i_if_req   (if_req),
        .i_dm_req   (dm_req),
        .i_dwin_max (r_dwin_cnt == DWIN_LIM),
        .o_gnt_if   (w_gnt_if),
        .o_gnt_dm   (w_gnt_dm)
    );

    // Requests are only considered while idle; grants are zero-latency.
    assign w_if_gnt = w_idle & w_gnt_if;
    assign w_dm_gnt = w_idle & w_gnt_dm;

    // Arbiter FSM with request capture, owner tracking, streak counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_dwin_cnt <= '0;
            r_err      <= 1'b0;
            r_mem_req  <= 1'b0;
            r_req      <= MEM_REQ_ZERO;
        end else begin
            // A response is only legal while waiting for one.
            if (mem_rvalid && !w_in_rsp) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end

            case (r_state)
                IDLE: begin
                    if (w_if_gnt) begin
                        r_req      <= fetch_req(if_adrs);
                        r_owner    <= OWN_IF;
                        r_dwin_cnt <= '0;
                        r_mem_req  <= 1'b1;
                        r_state    <= REQ;
                    end else if (w_dm_gnt) begin
                        r_req.adrs     <= dm_adrs;
                        r_req.wr_en    <= dm_wr_en;
                        r_req.byt_en   <= dm_byt_en;
                        r_req.sign_ext <= dm_sign_ext;
                        r_req.wr_data  <= dm_wr_data;
                        r_owner        <= OWN_DM;
                        // Streak only grows while fetch is actually waiting.
                        if (!if_req) begin
                            r_dwin_cnt <= '0;
                        end else if (r_dwin_cnt != DWIN_LIM) begin
                            r_dwin_cnt <= r_dwin_cnt + CNT_W'(1);
                        end else begin
                            r_dwin_cnt <= r_dwin_cnt;
                        end
                        r_mem_req <= 1'b1;
                        r_state   <= REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RSP;
                    end else begin
                        r_state <= REQ;
                    end
                end
                RSP: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RSP;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    // Response pulses are forwarded in the cycle they arrive, to the owner only.
    assign if_rvalid = w_in_rsp & mem_rvalid & (r_owner == OWN_IF);
    assign dm_rvalid = w_in_rsp & mem_rvalid & (r_owner == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

    assign mem_req      = r_mem_req;
    assign mem_wr_en    = r_req.wr_en;
    assign mem_byt_en   = r_req.byt_en;
    assign mem_sign_ext = r_req.sign_ext;
    assign mem_adrs     = r_req.adrs;
    assign mem_wr_data  = r_req.wr_data;

    assign busy = ~w_idle;
    assign err  = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAX_DWIN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_adrs;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_wr_en, dm_sign_ext;
    logic [3:0]  dm_byt_en;
    logic [31:0] dm_adrs, dm_wr_data;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_wr_en, mem_sign_ext;
    logic [3:0]  mem_byt_en;
    logic [31:0] mem_adrs, mem_wr_data;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy, err;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DWIN(MAX_DWIN)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adrs(if_adrs), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_wr_en(dm_wr_en), .dm_byt_en(dm_byt_en),
        .dm_sign_ext(dm_sign_ext), .dm_adrs(dm_adrs), .dm_wr_data(dm_wr_data),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_wr_en(mem_wr_en), .mem_byt_en(mem_byt_en),
        .mem_sign_ext(mem_sign_ext), .mem_adrs(mem_adrs), .mem_wr_data(mem_wr_data),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    bit          m_inflight, m_accepted, m_own_dm, m_err;
    int          m_streak;
    logic [31:0] m_adrs, m_wdata;
    logic        m_wr, m_sx;
    logic [3:0]  m_be;
    bit          e_if_gnt, e_dm_gnt, e_resp;
    logic [15:0] gnt_hist;
    int          gnt_n;

    task automatic model_reset();
        m_inflight = 0; m_accepted = 0; m_own_dm = 0; m_err = 0; m_streak = 0;
        m_adrs = 32'h0; m_wdata = 32'h0; m_wr = 1'b0; m_sx = 1'b0; m_be = 4'h0;
    endtask

    task automatic predict();
        e_if_gnt = !m_inflight && if_req && (!dm_req || m_streak == MAX_DWIN);
        e_dm_gnt = !m_inflight && dm_req && !e_if_gnt;
        e_resp   = m_inflight && m_accepted && mem_rvalid;
    endtask

    task automatic compare();
        bit e_mreq;
        e_mreq = m_inflight && !m_accepted;
        check("if_gnt", {31'b0, if_gnt}, {31'b0, e_if_gnt});
        check("dm_gnt", {31'b0, dm_gnt}, {31'b0, e_dm_gnt});
        check("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_resp && !m_own_dm});
        check("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, e_resp && m_own_dm});
        check("mem_req", {31'b0, mem_req}, {31'b0, e_mreq});
        check("busy", {31'b0, busy}, {31'b0, m_inflight});
        check("err", {31'b0, err}, {31'b0, m_err});
        if (e_mreq) begin
            check("mem_adrs", mem_adrs, m_adrs);
            check("mem_wr_data", mem_wr_data, m_wdata);
            check("mem_ctl", {26'b0, mem_wr_en, mem_byt_en, mem_sign_ext},
                  {26'b0, m_wr, m_be, m_sx});
        end
        if (e_resp && !m_own_dm) check("if_rdata", if_rdata, mem_rdata);
        if (e_resp && m_own_dm)  check("dm_rdata", dm_rdata, mem_rdata);
        if ((if_gnt || dm_gnt) && gnt_n < 16) begin
            gnt_hist[gnt_n] = if_gnt;
            gnt_n++;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            if (mem_rvalid && !(m_inflight && m_accepted)) m_err = 1;
            if (e_if_gnt) begin
                m_adrs = if_adrs; m_wr = 1'b0; m_be = 4'hF; m_sx = 1'b0; m_wdata = 32'h0;
                m_own_dm = 0; m_streak = 0; m_inflight = 1; m_accepted = 0;
            end else if (e_dm_gnt) begin
                m_adrs = dm_adrs; m_wr = dm_wr_en; m_be = dm_byt_en; m_sx = dm_sign_ext;
                m_wdata = dm_wr_data; m_own_dm = 1; m_inflight = 1; m_accepted = 0;
                if (!if_req) m_streak = 0;
                else if (m_streak < MAX_DWIN) m_streak = m_streak + 1;
            end else if (m_inflight && !m_accepted) begin
                if (mem_ready) m_accepted = 1;
            end else if (e_resp) begin
                m_inflight = 0;
            end
        end
    endtask

    // Inputs are set at negedge; outputs checked shortly after, model advances at posedge.
    task automatic step();
        predict();
        #1 compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_adrs = 32'h0;
        dm_req = 1'b0; dm_wr_en = 1'b0; dm_byt_en = 4'h0; dm_sign_ext = 1'b0;
        dm_adrs = 32'h0; dm_wr_data = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        gnt_hist = 16'h0; gnt_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_adrs", mem_adrs, 32'h0);
        check("rst_mem_byt_en", {28'b0, mem_byt_en}, 32'h0);
        step();

        // Single fetch
        if_req = 1'b1; if_adrs = 32'h0000_0010;
        #1 check("sf_gnt", {31'b0, if_gnt}, 32'd1);
        step();
        if_req = 1'b0; mem_ready = 1'b1;
        #1 check("sf_mem_req", {31'b0, mem_req}, 32'd1);
        check("sf_mem_adrs", mem_adrs, 32'h10);
        check("sf_mem_be", {28'b0, mem_byt_en}, 32'hF);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093;
        #1 check("sf_rvalid", {31'b0, if_rvalid}, 32'd1);
        check("sf_rdata", if_rdata, 32'h93);
        check("sf_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        #1 check("sf_busy_after", {31'b0, busy}, 32'd0);
        step();

        // Simultaneous requests: data first, fetch right after data response
        if_req = 1'b1; if_adrs = 32'h0000_0040;
        dm_req = 1'b1; dm_wr_en = 1'b0; dm_byt_en = 4'hF; dm_adrs = 32'h100;
        #1 check("sim_dm_first", {30'b0, dm_gnt, if_gnt}, 32'd2);
        step();
        dm_req = 1'b0; mem_ready = 1'b1;
        #1 check("sim_wr_en", {31'b0, mem_wr_en}, 32'd0);
        check("sim_adrs", mem_adrs, 32'h100);
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        #1 check("sim_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
        step();
        mem_rvalid = 1'b0;
        #1 check("sim_if_next", {31'b0, if_gnt}, 32'd1);
        step();
        if_req = 1'b0; mem_ready = 1'b1; step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; step();
        mem_rvalid = 1'b0; step();

        // Write with stall; requester fields change after grant
        dm_req = 1'b1; dm_wr_en = 1'b1; dm_adrs = 32'h200; dm_wr_data = 32'hDEAD_BEEF;
        dm_byt_en = 4'b0011; dm_sign_ext = 1'b0;
        step();
        dm_req = 1'b0; dm_adrs = 32'h0; dm_wr_data = 32'h1234_5678; dm_byt_en = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 check("wr_stall_data", mem_wr_data, 32'hDEAD_BEEF);
            check("wr_stall_adrs", mem_adrs, 32'h200);
            check("wr_stall_be", {28'b0, mem_byt_en}, 32'h3);
            step();
        end
        mem_ready = 1'b1; step();
        mem_ready = 1'b0; mem_rvalid = 1'b1;
        #1 check("wr_ack", {31'b0, dm_rvalid}, 32'd1);
        step();
        mem_rvalid = 1'b0; step();

        // Starvation limit: both held high, memory responds as fast as allowed
        if_req = 1'b1; dm_req = 1'b1; dm_wr_en = 1'b0;
        gnt_n = 0; gnt_hist = 16'h0;
        for (int i = 0; i < 40; i++) begin
            mem_ready  = m_inflight && !m_accepted;
            mem_rvalid = m_inflight && m_accepted;
            step();
        end
        check("starve_order", {22'b0, gnt_hist[9:0]}, 32'b10_0001_0000);
        if_req = 1'b0; dm_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready  = m_inflight && !m_accepted;
            mem_rvalid = m_inflight && m_accepted;
            step();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0; step();

        // Reset while in RSP, then a late response
        dm_req = 1'b1; step();
        dm_req = 1'b0; mem_ready = 1'b1; step();
        mem_ready = 1'b0; rst = 1'b1;
        #1 check("rr_busy_rsp", {31'b0, busy}, 32'd1);
        step();
        rst = 1'b0; mem_rvalid = 1'b1;
        #1 check("rr_no_rvalid", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
        check("rr_idle", {31'b0, busy}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        #1 check("rr_err", {31'b0, err}, 32'd1);
        step();
        rst = 1'b1; step(); rst = 1'b0;

        // Dropped request while in RSP
        dm_req = 1'b1; step();
        dm_req = 1'b0; mem_ready = 1'b1; step();
        mem_ready = 1'b0; if_req = 1'b1;
        #1 check("drop_no_gnt", {31'b0, if_gnt}, 32'd0);
        step();
        if_req = 1'b0; mem_rvalid = 1'b1; step();
        mem_rvalid = 1'b0;
        #1 check("drop_idle_gnt", {31'b0, if_gnt}, 32'd0);
        step();
        #1 check("drop_no_mem_req", {31'b0, mem_req}, 32'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!(if_req && !e_if_gnt) || $urandom_range(0, 19) == 0) begin
                if_req  = $urandom_range(0, 1);
                if_adrs = $urandom;
            end
            if (!(dm_req && !e_dm_gnt) || $urandom_range(0, 19) == 0) begin
                dm_req      = $urandom_range(0, 1);
                dm_adrs     = $urandom;
                dm_wr_data  = $urandom;
                dm_wr_en    = $urandom_range(0, 1);
                dm_byt_en   = 4'($urandom_range(0, 15));
                dm_sign_ext = $urandom_range(0, 1);
            end
            mem_ready  = $urandom_range(0, 1);
            mem_rvalid = (m_inflight && m_accepted) ? ($urandom_range(0, 2) != 0)
                                                    : ($urandom_range(0, 99) == 0);
            mem_rdata  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared memory port between the instruction-fetch requester and the data-access requester of the core. This lets one variable-latency unified memory replace separate instruction and data memories. The block allows one outstanding transaction at a time. Data has fixed priority over fetch, with a starvation limit that guarantees fetch progress. Responses are routed back to the requester that owns the transaction.

## Interface
- MAX_DWIN, 4: number of consecutive data grants allowed while fetch waits (must be ≥1).
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_adrs  in  32  fetch address.
- if_gnt  out  1  one-cycle grant; the fetch request is captured this cycle.
- if_rvalid  out  1  one-cycle fetch response valid.
- if_rdata  out  32  fetch read data; valid only with if_rvalid.
- dm_req  in  1  data request; held until dm_gnt.
- dm_wr_en  in  1  write (1) or read (0).
- dm_byt_en  in  4  byte enables.
- dm_sign_ext  in  1  sign-extend on a sub-word read.
- dm_adrs  in  32  data address.
- dm_wr_data  in  32  store data.
- dm_gnt  out  1  one-cycle data grant.
- dm_rvalid  out  1  data response (read data or write ack).
- dm_rdata  out  32  data read data.
- mem_req  out  1  request to memory; held until mem_ready.
- mem_wr_en, mem_byt_en, mem_sign_ext, mem_adrs, mem_wr_data  out  1/4/1/32/32  registered request fields.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response; also asserted for writes.
- mem_rdata  in  32  memory read data.
- busy  out  1  state ≠ IDLE.
- err  out  1  sticky protocol error.

## Operation
- FSM states are IDLE, REQ and RSP. An owner register (IF/DM) records whose transaction is in flight.
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick a winner, assert its gnt (combinational), capture its fields (fetch: wr_en=0, byt_en=4'b1111, sign_ext=0, wr_data=0), set owner, go to REQ.
- Winner selection:
  - Only one requester active: it wins.
  - Both active: DM wins unless dwin_cnt == MAX_DWIN, in which case IF wins.
- dwin_cnt update at each grant:
  - +1 on a DM grant while if_req=1.
  - Cleared on an IF grant.
  - Cleared on a DM grant while if_req=0.
  - Saturates at MAX_DWIN.
- REQ: mem_req=1 with the captured fields. When mem_ready=1, go to RSP; otherwise hold the fields stable.
- RSP: on mem_rvalid, pulse the owner's rvalid in the same cycle. Owner rdata = mem_rdata combinationally. Go to IDLE.
- The non-owner's rvalid is 0 at all times. rdata outputs may carry mem_rdata unconditionally.
- mem_rvalid in IDLE or REQ is ignored and sets err.
- Reset values: state=IDLE, owner=IF, dwin_cnt=0, err=0, mem_req=0, all captured fields 0, all gnt/rvalid=0, busy=0.

## Timing
- Grant occurs in the cycle the request is seen in IDLE: zero-cycle grant latency.
- mem_req is asserted at grant+1.
- mem_rvalid is forwarded in the same cycle it arrives.
- Minimum transaction: 3 cycles (grant, accept, response), achieved with mem_ready=1 at T+1 and mem_rvalid at T+2.
- Back-to-back transactions: the next grant comes no earlier than the cycle after rvalid, because the FSM returns to IDLE first.
- Requests are sampled only in IDLE. A request that drops before its grant is simply not serviced.
- The requester's input fields may change after gnt; the captured copy is used.
- Reset mid-transaction returns to IDLE immediately. Any late mem_rvalid is then ignored and flagged in err.
- Simultaneous if_req and dm_req when dwin_cnt < MAX_DWIN: DM is granted, IF waits.

## Structure
- cpu_pkg holds:
  - t_arb_state enum {IDLE, REQ, RSP}.
  - t_arb_owner enum {OWN_IF, OWN_DM}.
  - t_mem_req struct {adrs, wr_en, byt_en, sign_ext, wr_data}, used for the captured request and the mem_* outputs.
- Sub-module arb_prio is combinational. Inputs: if_req, dm_req, dwin_cnt==MAX_DWIN. Outputs: gnt_if, gnt_dm (one-hot or zero).
- The FSM, owner register, dwin_cnt and err all live in mem_arbiter.

## Test plan
- Single fetch:
  - Stimulus: if_req at 0x0000_0010; mem_ready=1 at T+1; mem_rvalid=1 with rdata 0x0000_0093 at T+2.
  - Required: if_gnt at T, mem_req at T+1, if_rvalid with if_rdata=0x93 at T+2, dm_rvalid=0 throughout, busy low at T+3.
- Simultaneous requests:
  - Stimulus: if_req and dm_req both high from IDLE; dm is a read at 0x100.
  - Required: dm_gnt first with mem_wr_en=0 and mem_adrs=0x100; if_gnt in the cycle after dm_rvalid.
- Starvation limit:
  - Stimulus: MAX_DWIN=4; dm_req and if_req held high continuously.
  - Required: grant order DM, DM, DM, DM, IF, DM, …; dwin_cnt=0 after the IF grant.
- Write with stall:
  - Stimulus: dm write to 0x200 with data 0xDEADBEEF and byt_en 4'b0011; mem_ready held low for 3 cycles.
  - Required: mem_* fields stable over those cycles, RSP entered only after mem_ready=1, dm_rvalid on the ack.
- Reset mid-transaction:
  - Stimulus: rst in RSP, followed by mem_rvalid=1 in the cycle after reset.
  - Required: state=IDLE, no rvalid output, err=1.
- Dropped request:
  - Stimulus: if_req high for one cycle while in RSP, then low before IDLE.
  - Required: no if_gnt and no mem_req issued for it.
